// File: rtl/iob_ptfloat2double_arb.sv
// Round-robin arbiter sharing one pt-float to IEEE-754 double converter among
// N_REQ requesters: capture, start, wait with timeout, respond.
module iob_ptfloat2double_arb #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned EXP_W   = 8,
    parameter int unsigned MAN_W   = 24,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     cke_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*EXP_W-1:0]   req_exp_i,
    input  logic [N_REQ*MAN_W-1:0]   req_man_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [N_REQ-1:0]         rsp_valid_o,
    output logic [63:0]              rsp_fp_o,
    output logic                     rsp_err_o,
    output logic                     busy_o,
    output logic                     conv_start_o,
    output logic [EXP_W-1:0]         conv_exp_o,
    output logic [MAN_W-1:0]         conv_man_o,
    input  logic                     conv_done_i,
    input  logic [63:0]              conv_fp_i
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned TW = $clog2(TIMEOUT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]       state, state_d;
    logic [IW-1:0]    last_gnt, last_gnt_d;
    logic [IW-1:0]    cur, cur_d;
    logic [TW-1:0]    timer, timer_d;
    logic [IW-1:0]    winner;
    logic             any_req;
    logic [EXP_W-1:0] exp_d;
    logic [MAN_W-1:0] man_d;
    logic [63:0]      fp_d;
    logic             err_d;
    logic             start_d;
    logic             busy_d;
    logic [N_REQ-1:0] valid_d;

    // Round-robin search starting just after the last served requester
    always_comb begin
        int unsigned idx;
        logic        found;
        idx    = 0;
        found  = 1'b0;
        winner = last_gnt;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = (32'(last_gnt) + i) % N_REQ;
            if (!found && req_i[IW'(idx)]) begin
                winner = IW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req_i;

    // Capture strobe coincides with the IDLE cycle whose closing edge latches operands
    assign gnt_o = (state == IDLE && cke_i && !arst_i && any_req)
                   ? (N_REQ'(1) << winner) : '0;

    always_comb begin
        state_d    = state;
        cur_d      = cur;
        last_gnt_d = last_gnt;
        timer_d    = timer;
        exp_d      = conv_exp_o;
        man_d      = conv_man_o;
        fp_d       = rsp_fp_o;
        err_d      = rsp_err_o;
        start_d    = 1'b0;
        valid_d    = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    cur_d   = winner;
                    exp_d   = req_exp_i[32'(winner)*EXP_W +: EXP_W];
                    man_d   = req_man_i[32'(winner)*MAN_W +: MAN_W];
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A completion in the timeout cycle takes precedence
                if (conv_done_i) begin
                    fp_d    = conv_fp_i;
                    err_d   = 1'b0;
                    valid_d = N_REQ'(1) << cur;
                    state_d = RESP;
                end else if (timer == TW'(TIMEOUT - 2)) begin
                    timer_d = timer + TW'(1);
                    fp_d    = '0;
                    err_d   = 1'b1;
                    valid_d = N_REQ'(1) << cur;
                    state_d = RESP;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            RESP: begin
                last_gnt_d = cur;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state        <= IDLE;
            cur          <= '0;
            last_gnt     <= IW'(N_REQ - 1);
            timer        <= '0;
            conv_exp_o   <= '0;
            conv_man_o   <= '0;
            rsp_fp_o     <= '0;
            rsp_err_o    <= 1'b0;
            conv_start_o <= 1'b0;
            rsp_valid_o  <= '0;
            busy_o       <= 1'b0;
        end else if (cke_i) begin
            state        <= state_d;
            cur          <= cur_d;
            last_gnt     <= last_gnt_d;
            timer        <= timer_d;
            conv_exp_o   <= exp_d;
            conv_man_o   <= man_d;
            rsp_fp_o     <= fp_d;
            rsp_err_o    <= err_d;
            conv_start_o <= start_d;
            rsp_valid_o  <= valid_d;
            busy_o       <= busy_d;
        end
    end

endmodule
